// File: rtl/vga_timing_pkg.sv
// Shared constants, state encoding and the line/width qualifier for vga_timing_checker.
// Optional macro VGA_TIMING_TOL_EN: when defined, accept line period and hsync width within +/-1.
package vga_timing_pkg;

  localparam int DEF_H_DISP = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_H_TOTAL = DEF_H_DISP + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_DISP = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;
  localparam int DEF_V_TOTAL = DEF_V_DISP + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam logic DEF_SYNC_POL    = 1'b1;
  localparam int   DEF_LOCK_FRAMES = 2;

  localparam logic [9:0] CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Horizontal measurements only; vertical counts are always compared exactly.
  function automatic logic len_ok(input logic [9:0] meas, input int nominal);
    int m;
    m = int'(meas);
`ifdef VGA_TIMING_TOL_EN
    return (m >= nominal - 1) && (m <= nominal + 1);
`else
    return m == nominal;
`endif
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Registered previous sync level with pix_tick-gated lead/trail strobes.
module vga_sync_edge
  import vga_timing_pkg::*;
#(
  parameter logic SYNC_POL = DEF_SYNC_POL
)(
  input  logic clk,
  input  logic reset,
  input  logic pix_tick,
  input  logic sync_in,
  output logic active,
  output logic lead,
  output logic trail
);

  logic prev_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_level <= 1'b0;
    end else if (pix_tick) begin
      prev_level <= sync_in;
    end
  end

  assign active = (sync_in == SYNC_POL);
  assign lead   = pix_tick & active & (prev_level != SYNC_POL);
  assign trail  = pix_tick & ~active & (prev_level == SYNC_POL);

endmodule

// File: rtl/vga_timing_checker.sv
// Receive-side 640x480 sync checker: measures sync timing, locks and regenerates pixel position.
// Optional macro VGA_TIMING_TOL_EN widens the line-period and hsync-width acceptance to +/-1.
//
// state  | meaning
// SEARCH | no reference yet; first partial frame is discarded
// CHECK  | counting consecutive good frames toward lock
// LOCKED | timing matches; pos_valid may assert
module vga_timing_checker
  import vga_timing_pkg::*;
#(
  parameter int   H_DISP      = DEF_H_DISP,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_DISP      = DEF_V_DISP,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter logic SYNC_POL    = DEF_SYNC_POL,
  parameter int   LOCK_FRAMES = DEF_LOCK_FRAMES
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_tick,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  output logic       locked,
  output logic       frame_err,
  output logic       sync_lost,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic [9:0] hsync_w,
  output logic [9:0] vsync_w,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       pos_valid
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_LOAD  = 10'(H_DISP + H_FP);
  localparam logic [9:0] Y_LOAD  = 10'(V_DISP + V_FP);
  localparam logic [9:0] X_VIS   = 10'(H_DISP);
  localparam logic [9:0] Y_VIS   = 10'(V_DISP);
  localparam logic [9:0] V_TOT_C = 10'(V_TOTAL);
  localparam logic [9:0] V_SYN_C = 10'(V_SYNC);
  localparam logic [3:0] LOCK_C  = 4'(LOCK_FRAMES);

  logic hs_active, hs_lead, hs_trail;
  logic vs_active, vs_lead, vs_trail;

  vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_hs_edge (
    .clk      (clk),
    .reset    (reset),
    .pix_tick (pix_tick),
    .sync_in  (h_sync_in),
    .active   (hs_active),
    .lead     (hs_lead),
    .trail    (hs_trail)
  );

  vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_vs_edge (
    .clk      (clk),
    .reset    (reset),
    .pix_tick (pix_tick),
    .sync_in  (v_sync_in),
    .active   (vs_active),
    .lead     (vs_lead),
    .trail    (vs_trail)
  );

  logic [9:0] h_cnt, hw_cnt, v_cnt, vw_cnt;
  logic [9:0] frame_lines_new;
  logic       h_lost, bad_now, line_bad, frame_ok, x_wrap;

  state_t     state_q, state_d;
  logic [3:0] good_q, good_d, good_inc;
  logic       err_d;

  assign h_lost          = pix_tick & ~hs_lead & (h_cnt == CNT_MAX - 10'd1);
  assign frame_lines_new = v_cnt + {9'd0, hs_lead};
  assign x_wrap          = ~hs_lead & (pos_x == H_LAST);

  // An hs edge coincident with vs lead still belongs to the frame being closed.
  assign bad_now  = (hs_lead & ~len_ok(h_cnt, H_TOTAL)) |
                    (hs_trail & ~len_ok(hw_cnt, H_SYNC));
  assign frame_ok = ~(line_bad | bad_now) & (frame_lines_new == V_TOT_C) &
                    (vsync_w == V_SYN_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt     <= '0;
      hw_cnt    <= '0;
      line_len  <= '0;
      hsync_w   <= '0;
      sync_lost <= 1'b0;
    end else begin
      sync_lost <= h_lost;
      if (pix_tick) begin
        if (hs_lead) begin
          line_len <= h_cnt;
          h_cnt    <= 10'd1;
        end else if (h_cnt != CNT_MAX) begin
          h_cnt <= h_cnt + 10'd1;
        end

        if (hs_lead) begin
          hw_cnt <= 10'd1;
        end else if (hs_active && hw_cnt != CNT_MAX) begin
          hw_cnt <= hw_cnt + 10'd1;
        end

        if (hs_trail) begin
          hsync_w <= hw_cnt;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_cnt       <= '0;
      vw_cnt      <= '0;
      frame_lines <= '0;
      vsync_w     <= '0;
      line_bad    <= 1'b0;
    end else if (pix_tick) begin
      if (vs_lead) begin
        frame_lines <= frame_lines_new;
        v_cnt       <= '0;
        vw_cnt      <= {9'd0, hs_lead};
      end else begin
        if (hs_lead && v_cnt != CNT_MAX) begin
          v_cnt <= v_cnt + 10'd1;
        end
        if (vs_active && hs_lead && vw_cnt != CNT_MAX) begin
          vw_cnt <= vw_cnt + 10'd1;
        end
      end

      if (vs_trail) begin
        vsync_w <= vw_cnt;
      end

      if (vs_lead) begin
        line_bad <= 1'b0;
      end else if (bad_now) begin
        line_bad <= 1'b1;
      end
    end
  end

  assign good_inc = good_q + 4'd1;

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = 1'b0;
    if (h_lost) begin
      state_d = SEARCH;
      good_d  = '0;
    end else if (vs_lead) begin
      case (state_q)
        SEARCH: begin
          state_d = CHECK;
          good_d  = '0;
        end
        CHECK: begin
          if (frame_ok) begin
            good_d = good_inc;
            if (good_inc >= LOCK_C) begin
              state_d = LOCKED;
            end
          end else begin
            good_d = '0;
            err_d  = 1'b1;
          end
        end
        LOCKED: begin
          if (!frame_ok) begin
            state_d = CHECK;
            good_d  = '0;
            err_d   = 1'b1;
          end
        end
        default: begin
          state_d = SEARCH;
          good_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SEARCH;
      good_q    <= '0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      frame_err <= err_d;
    end
  end

  assign locked = (state_q == LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (pix_tick) begin
      if (hs_lead) begin
        pos_x <= X_LOAD;
      end else if (pos_x == H_LAST) begin
        pos_x <= '0;
      end else begin
        pos_x <= pos_x + 10'd1;
      end

      if (vs_lead) begin
        pos_y <= Y_LOAD;
      end else if (x_wrap) begin
        pos_y <= (pos_y == V_LAST) ? 10'd0 : pos_y + 10'd1;
      end
    end
  end

  assign pos_valid = locked & (pos_x < X_VIS) & (pos_y < Y_VIS);

endmodule

// File: tb/tb_vga_timing_checker.sv
// Directed bench for vga_timing_checker using a reduced 25x11 raster so whole frames run quickly.
module tb_vga_timing_checker;

  // Reduced raster: H 16+2+4+3 = 25 ticks, V 6+1+2+2 = 11 lines.
  localparam int HT   = 25;
  localparam int X_HS = 18;
  localparam int X_HE = 22;

`ifdef VGA_TIMING_TOL_EN
  localparam int TOL = 1;
`else
  localparam int TOL = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, pix_tick, h_sync_in, v_sync_in;
  logic       locked, frame_err, sync_lost, pos_valid;
  logic [9:0] line_len, frame_lines, hsync_w, vsync_w, pos_x, pos_y;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int sl_cnt = 0;
  int sl_first = 0;
  int tick_no = 0;
  int tick_base, fe_base;
  bit chk_pos = 1'b0;
  int hold_y = -1;

  always #5 clk = ~clk;

  vga_timing_checker #(
    .H_DISP(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_DISP(6),  .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1), .LOCK_FRAMES(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_tick    (pix_tick),
    .h_sync_in   (h_sync_in),
    .v_sync_in   (v_sync_in),
    .locked      (locked),
    .frame_err   (frame_err),
    .sync_lost   (sync_lost),
    .line_len    (line_len),
    .frame_lines (frame_lines),
    .hsync_w     (hsync_w),
    .vsync_w     (vsync_w),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .pos_valid   (pos_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_sync_lost"}, sync_lost, 0);
    check({tag, "_line_len"}, line_len, 0);
    check({tag, "_frame_lines"}, frame_lines, 0);
    check({tag, "_hsync_w"}, hsync_w, 0);
    check({tag, "_vsync_w"}, vsync_w, 0);
    check({tag, "_pos_x"}, pos_x, 0);
    check({tag, "_pos_y"}, pos_y, 0);
    check({tag, "_pos_valid"}, pos_valid, 0);
  endtask

  // One pixel tick followed by one idle clock; called and returns on a negedge.
  task automatic px(input logic hs, input logic vs);
    h_sync_in = hs;
    v_sync_in = vs;
    pix_tick  = 1'b1;
    @(negedge clk);
    pix_tick = 1'b0;
    tick_no++;
    if (frame_err) fe_cnt++;
    if (sync_lost) begin
      if (sl_cnt == 0) sl_first = tick_no;
      sl_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic do_hold(input int y);
    repeat (50) begin
      h_sync_in = ~h_sync_in;
      v_sync_in = ~v_sync_in;
      @(negedge clk);
    end
    check("hold_pos_x", pos_x, 10);
    check("hold_pos_y", pos_y, y);
    check("hold_locked", locked, 1);
    check("hold_line_len", line_len, HT);
    check("hold_hsync_w", hsync_w, 4);
    check("hold_frame_lines", frame_lines, 11);
  endtask

  // vs rises at (line 7, column vs_x) and lasts two lines; long_y gets one extra tick.
  task automatic gen_frame(input int vs_x, input int long_y, input int exp_b,
                           input int exp_a, input int last_y);
    int len;
    for (int y = 0; y <= last_y; y++) begin
      len = (y == long_y) ? HT + 1 : HT;
      for (int x = 0; x < len; x++) begin
        px(x >= X_HS && x < X_HE,
           (y == 7 && x >= vs_x) || (y == 8) || (y == 9 && x < vs_x));
        if (exp_b >= 0 && ((vs_x == 0 && y == 6 && x == len - 1) ||
                           (vs_x > 0 && y == 7 && x == vs_x - 1)))
          check("lock_before_vs", locked, exp_b);
        if (exp_a >= 0 && y == 7 && x == vs_x)
          check("lock_after_vs", locked, exp_a);
        if (long_y >= 0 && y == long_y + 1 && x == 20)
          check("long_line_len", line_len, HT + 1);
        if (chk_pos && y == 3 && x == 5) begin
          check("pos_x_vis", pos_x, 5);
          check("pos_y_vis", pos_y, 3);
          check("pos_valid_vis", pos_valid, 1);
        end
        if (chk_pos && y == 3 && x == 20) begin
          check("pos_x_hblank", pos_x, 20);
          check("pos_valid_hblank", pos_valid, 0);
        end
        if (chk_pos && y == 9 && x == 5) begin
          check("pos_y_vblank", pos_y, 9);
          check("pos_valid_vblank", pos_valid, 0);
        end
        if (y == hold_y && x == 10) do_hold(y);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    pix_tick = 1'b0;
    h_sync_in = 1'b0;
    v_sync_in = 1'b0;
    repeat (3) @(negedge clk);
    outputs_zero("rst");
    reset = 1'b0;
    @(negedge clk);

    // Lock sequence: SEARCH -> CHECK -> good 1 -> LOCKED at the 3rd vs lead.
    gen_frame(0, -1, 0, 0, 10);
    gen_frame(0, -1, 0, 0, 10);
    gen_frame(0, -1, 0, 1, 10);
    check("line_len", line_len, HT);
    check("frame_lines", frame_lines, 11);
    check("hsync_w", hsync_w, 4);
    check("vsync_w", vsync_w, 2);
    check("no_frame_err", fe_cnt, 0);

    chk_pos = 1'b1;
    hold_y  = 4;
    gen_frame(0, -1, 1, 1, 10);
    chk_pos = 1'b0;
    hold_y  = -1;
    check("no_err_after_hold", fe_cnt, 0);

    // One 26-tick line while locked.
    gen_frame(0, 2, 1, TOL ? 1 : 0, 10);
    check("long_frame_err", fe_cnt, TOL ? 0 : 1);
    gen_frame(0, -1, TOL, TOL, 10);
    gen_frame(0, -1, TOL, 1, 10);

    // Move vs lead onto an hs lead: transition frame has 12 leads, then 11.
    fe_base = fe_cnt;
    gen_frame(18, -1, 1, 0, 10);
    check("shift_frame_lines", frame_lines, 12);
    check("shift_frame_err", fe_cnt - fe_base, 1);
    gen_frame(18, -1, 0, 0, 10);
    check("coinc_frame_lines", frame_lines, 11);
    check("coinc_vsync_w", vsync_w, 2);
    gen_frame(18, -1, 0, 1, 10);

    // hsync absent: h_cnt ends the last line at 7, so it hits 1023 on idle tick 1016.
    fe_base = fe_cnt;
    tick_base = tick_no;
    repeat (1100) px(1'b0, 1'b0);
    check("sync_lost_count", sl_cnt, 1);
    check("sync_lost_tick", sl_first - tick_base, 1016);
    check("sync_lost_unlocked", locked, 0);
    check("sync_lost_no_frame_err", fe_cnt - fe_base, 0);
    gen_frame(0, -1, 0, 0, 10);
    gen_frame(0, -1, 0, 0, 10);
    gen_frame(0, -1, 0, 1, 10);

    // Asynchronous reset in mid-frame while locked.
    gen_frame(0, -1, -1, -1, 4);
    check("pre_reset_locked", locked, 1);
    #2 reset = 1'b1;
    #1 outputs_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    gen_frame(0, -1, 0, 0, 10);
    gen_frame(0, -1, 0, 0, 10);
    gen_frame(0, -1, 0, 1, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_checker.md
Name: vga_timing_checker

Overview:
Receive-side companion to the 640x480 sync generator. Samples incoming h_sync/v_sync on the shared pixel-tick enable and measures line length, lines per frame and sync widths. Locks onto the stream, flags timing errors and regenerates pixel coordinates. Used in loopback self-test and to qualify sync from a foreign source before the colour pipeline consumes it.

Parameters:
H_DISP, 640, visible pixels per line
H_FP, 16, horizontal front porch (ticks)
H_SYNC, 96, hsync width (ticks)
H_BP, 48, horizontal back porch (ticks)
V_DISP, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 1, active level of both sync inputs
LOCK_FRAMES, 2, consecutive good frames required to lock

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
pix_tick  in  1  one-clk pixel enable (25 MHz rate)
h_sync_in  in  1  horizontal sync under test
v_sync_in  in  1  vertical sync under test
locked  out  1  timing matches parameters
frame_err  out  1  one-clk pulse: bad frame seen while CHECK/LOCKED
sync_lost  out  1  one-clk pulse: hsync absent (h_cnt saturated)
line_len  out  10  last measured hsync lead-to-lead period (ticks)
frame_lines  out  10  last measured lines per frame
hsync_w  out  10  last measured hsync width (ticks)
vsync_w  out  10  last measured vsync width (lines)
pos_x  out  10  regenerated column
pos_y  out  10  regenerated row
pos_valid  out  1  locked & pos_x<H_DISP & pos_y<V_DISP

Behaviour:
- Reset: every output 0; internal counters 0; state SEARCH.
- All sampling and state updates occur only on clk edges where pix_tick=1. With pix_tick=0, all state holds.
- Edge detect per sync: registered previous level. lead = (in==SYNC_POL)&(prev!=SYNC_POL). trail is the converse.
- h_cnt: on hs lead, line_len<=h_cnt and h_cnt<=1. Otherwise h_cnt increments, saturating at 1023. Reaching 1023 pulses sync_lost and forces SEARCH.
- hw_cnt: 1 at hs lead, +1 while active. On hs trail, hsync_w<=hw_cnt.
- v_cnt: +1 per hs lead, saturating at 1023. On vs lead, frame_lines<=v_cnt+(hs lead same tick ? 1 : 0), then v_cnt<=0.
- vw_cnt: on vs lead, <=(hs lead ? 1 : 0). While vs active, +1 per hs lead. On vs trail, vsync_w<=vw_cnt.
- line_bad (sticky):
  - Set on any hs lead with captured period != H_TOTAL (H_DISP+H_FP+H_SYNC+H_BP=800).
  - Set on any hs trail with width != H_SYNC.
  - Cleared at vs lead.
- frame_ok, evaluated at vs lead: !line_bad & frame_lines==V_TOTAL (525) & vsync_w==V_SYNC.
- FSM, transitions at vs lead:
  - SEARCH: goes to CHECK with good_cnt=0. The first partial frame is ignored.
  - CHECK: frame_ok -> good_cnt+1. On reaching LOCK_FRAMES -> LOCKED. !frame_ok -> good_cnt=0 and frame_err pulse.
  - LOCKED: !frame_ok -> CHECK with good_cnt=0 and frame_err pulse.
  - sync_lost overrides from any state, going to SEARCH.
- locked = (state==LOCKED), registered, asserted the clk after the qualifying vs lead.
- pos_x:
  - Loaded H_DISP+H_FP (656) at hs lead.
  - Otherwise increments per tick, wrapping from H_TOTAL-1 to 0.
- pos_y:
  - Loaded V_DISP+V_FP (490) at vs lead; vs lead takes priority over the wrap.
  - Otherwise increments when pos_x wraps to 0, wrapping from V_TOTAL-1 to 0.
- Reset mid-frame: immediate return to reset values. Lock requires a fresh SEARCH->CHECK->LOCKED sequence.

Optional Feature:
VGA_TIMING_TOL_EN: when defined, a line period of H_TOTAL±1 and an hsync width of H_SYNC±1 count as good. When undefined, both must match exactly. frame_lines and vsync_w are always exact.

Decomposition:
- Package vga_timing_pkg holds:
  - all porch/sync/display constants and the derived H_TOTAL/V_TOTAL;
  - the state encoding (SEARCH=0, CHECK=1, LOCKED=2).
- Sub-module vga_sync_edge: registered level plus lead/trail strobes gated by pix_tick and SYNC_POL. Instantiated once for h and once for v.

Test Plan:
- Ideal 640x480 stream from the generator, pix_tick every 2nd clk -> locked rises one clk after the 3rd vs lead. Reads back line_len=800, frame_lines=525, hsync_w=96, vsync_w=2. pos_x/pos_y track the generator's pixel_x/pixel_y once locked.
- While locked, lengthen one line to 801 ticks -> frame_err pulse at the next vs lead and locked=0. Relocks after 2 further good frames (with VGA_TIMING_TOL_EN: no error).
- Hold h_sync_in inactive for 1100 ticks -> sync_lost pulse when h_cnt reaches 1023, locked=0, state SEARCH.
- vsync lead coincident with an hs lead -> frame_lines=525, not 524 or 526.
- Assert reset mid-frame while locked -> all outputs 0 immediately. Lock returns only after the full 3-vs-lead sequence.
- pix_tick held low for 50 clks mid-line -> no counter, output or state changes.
